// File: rtl/lift_car_controller.sv
// Per-car lift controller: latches dispatcher assignments and cab buttons into a
// pending-stop set and serves them with a SCAN (collective) travel policy.
module lift_car_controller #(
  parameter int NUM_FLOORS  = 11,
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  assign_valid,
  input  logic [3:0]            assign_floor,
  input  logic [NUM_FLOORS-1:0] cab_req,
  output logic [3:0]            cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  served_valid,
  output logic [3:0]            served_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TW = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [TW-1:0] FLOOR_LOAD = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LOAD  = TW'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {IDLE, MOVE, ARRIVE, DOOR} state_t;

  state_t                state;
  logic [TW-1:0]         timer;
  logic [NUM_FLOORS-1:0] req_set;
  logic [NUM_FLOORS-1:0] here_mask;
  logic [NUM_FLOORS-1:0] above_mask;
  logic [NUM_FLOORS-1:0] below_mask;
  logic [NUM_FLOORS-1:0] latch_set;
  logic                  here_req;
  logic                  above_any;
  logic                  below_any;
  logic                  ahead;
  logic                  behind;
  logic                  absorb;

  // Out-of-range assignment floors never match a bit, so they drop out here.
  always_comb begin
    req_set    = cab_req;
    here_mask  = '0;
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (assign_valid && assign_floor == 4'(i)) req_set[i] = 1'b1;
      if (cur_floor == 4'(i)) here_mask[i] = 1'b1;
      if (4'(i) > cur_floor) above_mask[i] = 1'b1;
      if (4'(i) < cur_floor) below_mask[i] = 1'b1;
    end
  end

  assign here_req  = |(pending & here_mask);
  assign above_any = |(pending & above_mask);
  assign below_any = |(pending & below_mask);
  assign ahead     = dir_up ? above_any : below_any;
  assign behind    = dir_up ? below_any : above_any;
  // A request for the floor whose door is already open is served in place.
  assign absorb    = (state == DOOR) && |(req_set & here_mask);
  assign latch_set = absorb ? (req_set & ~here_mask) : req_set;
  assign busy      = (state != IDLE) || (|pending);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      cur_floor    <= 4'd0;
      dir_up       <= 1'b1;
      moving       <= 1'b0;
      door_open    <= 1'b0;
      served_valid <= 1'b0;
      served_floor <= 4'd0;
      pending      <= '0;
    end else begin
      served_valid <= 1'b0;
      pending      <= pending | latch_set;
      case (state)
        IDLE: begin
          if (here_req) begin
            state        <= DOOR;
            door_open    <= 1'b1;
            timer        <= DOOR_LOAD;
            pending      <= (pending & ~here_mask) | latch_set;
            served_valid <= 1'b1;
            served_floor <= cur_floor;
          end else if (ahead || behind) begin
            if (!ahead) dir_up <= ~dir_up;
            state  <= MOVE;
            moving <= 1'b1;
            timer  <= FLOOR_LOAD;
          end
        end
        MOVE: begin
          if (timer == '0) begin
            state     <= ARRIVE;
            moving    <= 1'b0;
            cur_floor <= dir_up ? cur_floor + 4'd1 : cur_floor - 4'd1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ARRIVE: begin
          if (here_req) begin
            state        <= DOOR;
            door_open    <= 1'b1;
            timer        <= DOOR_LOAD;
            pending      <= (pending & ~here_mask) | latch_set;
            served_valid <= 1'b1;
            served_floor <= cur_floor;
          end else if (ahead) begin
            state  <= MOVE;
            moving <= 1'b1;
            timer  <= FLOOR_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          if (absorb) begin
            timer        <= DOOR_LOAD;
            served_valid <= 1'b1;
            served_floor <= cur_floor;
          end else if (timer == '0) begin
            state     <= IDLE;
            door_open <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lift_car_controller.sv
// Bench for lift_car_controller: directed scenarios plus random traffic, all
// checked cycle by cycle against a floor-list reference model.
module tb_lift_car_controller;

  localparam int NF = 11;
  localparam int FT = 4;
  localparam int DT = 3;
  localparam int M_IDLE = 0, M_MOVE = 1, M_ARRIVE = 2, M_DOOR = 3;

  logic          clk;
  logic          rst;
  logic          assign_valid;
  logic [3:0]    assign_floor;
  logic [NF-1:0] cab_req;
  logic [3:0]    cur_floor;
  logic          dir_up;
  logic          moving;
  logic          door_open;
  logic          served_valid;
  logic [3:0]    served_floor;
  logic [NF-1:0] pending;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int max_floor;
  int served_q[$];

  // Reference model: car position, travel sense, activity and remaining cycles.
  int m_floor;
  bit m_up;
  int m_mode;
  int m_cnt;
  bit m_req[NF];
  bit m_sv;
  int m_sf;

  lift_car_controller #(.NUM_FLOORS(NF), .FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .assign_valid(assign_valid), .assign_floor(assign_floor),
    .cab_req(cab_req), .cur_floor(cur_floor), .dir_up(dir_up), .moving(moving),
    .door_open(door_open), .served_valid(served_valid), .served_floor(served_floor),
    .pending(pending), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NF-1:0] onehot(input int f);
    logic [NF-1:0] v;
    v = '0;
    v[f] = 1'b1;
    return v;
  endfunction

  function automatic bit any_req(input int lo, input int hi);
    for (int f = lo; f <= hi; f++) if (m_req[f]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NF-1:0] m_pending();
    logic [NF-1:0] v;
    for (int f = 0; f < NF; f++) v[f] = m_req[f];
    return v;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_up = 1'b1; m_mode = M_IDLE; m_cnt = 0; m_sv = 1'b0; m_sf = 0;
    for (int f = 0; f < NF; f++) m_req[f] = 1'b0;
  endtask

  task automatic model_step(input bit av, input logic [3:0] af, input logic [NF-1:0] cab);
    bit inc[NF];
    bit above, below, ahead, behind, absorbed, sv_n;
    for (int f = 0; f < NF; f++) inc[f] = cab[f] || (av && int'(af) == f);
    above    = any_req(m_floor + 1, NF - 1);
    below    = any_req(0, m_floor - 1);
    ahead    = m_up ? above : below;
    behind   = m_up ? below : above;
    absorbed = (m_mode == M_DOOR) && inc[m_floor];
    if (absorbed) inc[m_floor] = 1'b0;
    sv_n = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (m_req[m_floor]) begin
          m_mode = M_DOOR; m_cnt = DT; m_req[m_floor] = 1'b0; sv_n = 1'b1;
        end else if (ahead) begin
          m_mode = M_MOVE; m_cnt = FT;
        end else if (behind) begin
          m_up = !m_up; m_mode = M_MOVE; m_cnt = FT;
        end
      end
      M_MOVE: begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_floor += m_up ? 1 : -1;
          m_mode = M_ARRIVE;
        end
      end
      M_ARRIVE: begin
        if (m_req[m_floor]) begin
          m_mode = M_DOOR; m_cnt = DT; m_req[m_floor] = 1'b0; sv_n = 1'b1;
        end else if (ahead) begin
          m_mode = M_MOVE; m_cnt = FT;
        end else begin
          m_mode = M_IDLE;
        end
      end
      default: begin
        if (absorbed) begin
          m_cnt = DT; sv_n = 1'b1;
        end else begin
          m_cnt--;
          if (m_cnt == 0) m_mode = M_IDLE;
        end
      end
    endcase
    for (int f = 0; f < NF; f++) if (inc[f]) m_req[f] = 1'b1;
    m_sv = sv_n;
    if (sv_n) m_sf = m_floor;
  endtask

  task automatic compare_all();
    chk("cur_floor", 32'(cur_floor), 32'(m_floor));
    chk("dir_up", 32'(dir_up), 32'(m_up));
    chk("moving", 32'(moving), 32'(m_mode == M_MOVE));
    chk("door_open", 32'(door_open), 32'(m_mode == M_DOOR));
    chk("served_valid", 32'(served_valid), 32'(m_sv));
    if (m_sv) chk("served_floor", 32'(served_floor), 32'(m_sf));
    chk("pending", 32'(pending), 32'(m_pending()));
    chk("busy", 32'(busy), 32'((m_mode != M_IDLE) || (m_pending() != '0)));
  endtask

  // Drive one cycle of inputs (called at a falling edge), then observe the next cycle.
  task automatic tick(input bit av, input logic [3:0] af, input logic [NF-1:0] cab);
    assign_valid = av; assign_floor = af; cab_req = cab;
    model_step(av, af, cab);
    @(posedge clk);
    @(negedge clk);
    assign_valid = 1'b0; assign_floor = 4'd0; cab_req = '0;
    cyc++;
    compare_all();
    if (served_valid) served_q.push_back(int'(served_floor));
    if (int'(cur_floor) > max_floor) max_floor = int'(cur_floor);
  endtask

  task automatic idle_tick();
    tick(1'b0, 4'd0, '0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin idle_tick(); n++; end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_floor"}, 32'(cur_floor), 32'd0);
    chk({tag, "_dir"}, 32'(dir_up), 32'd1);
    chk({tag, "_moving"}, 32'(moving), 32'd0);
    chk({tag, "_door"}, 32'(door_open), 32'd0);
    chk({tag, "_sv"}, 32'(served_valid), 32'd0);
    chk({tag, "_sf"}, 32'(served_floor), 32'd0);
    chk({tag, "_pending"}, 32'(pending), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int door_cnt;
    bit seen8;
    rst = 1'b0; assign_valid = 1'b0; assign_floor = 4'd0; cab_req = '0;
    max_floor = 0;
    model_reset();
    #1 rst = 1'b1;
    #1 check_reset_values("rst0");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single assignment to floor 3 from floor 0, with absolute cycle timing.
    tick(1'b1, 4'd3, '0);
    chk("t1_k1_moving", 32'(moving), 32'd0);
    for (int k = 2; k <= 20; k++) begin
      idle_tick();
      case (k)
        2:  chk("t1_move_entry", 32'(moving), 32'd1);
        6:  chk("t1_floor1", 32'(cur_floor), 32'd1);
        11: chk("t1_floor2", 32'(cur_floor), 32'd2);
        15: chk("t1_not_yet3", 32'(cur_floor), 32'd2);
        16: chk("t1_floor3", 32'(cur_floor), 32'd3);
        17: begin
          chk("t1_door", 32'(door_open), 32'd1);
          chk("t1_sv", 32'(served_valid), 32'd1);
          chk("t1_sf", 32'(served_floor), 32'd3);
        end
        19: chk("t1_door_held", 32'(door_open), 32'd1);
        20: begin
          chk("t1_door_closed", 32'(door_open), 32'd0);
          chk("t1_busy", 32'(busy), 32'd0);
          chk("t1_pending", 32'(pending), 32'd0);
        end
        default: ;
      endcase
    end

    // SCAN: heading up to 7, floor 2 requested once past floor 5.
    served_q.delete();
    tick(1'b1, 4'd7, '0);
    n = 0;
    while (cur_floor != 4'd5 && n < 100) begin idle_tick(); n++; end
    chk("scan_reach5", 32'(cur_floor), 32'd5);
    tick(1'b1, 4'd2, '0);
    wait_idle("scan_done", 400);
    chk("scan_count", 32'(served_q.size()), 32'd2);
    if (served_q.size() == 2) begin
      chk("scan_first", 32'(served_q[0]), 32'd7);
      chk("scan_second", 32'(served_q[1]), 32'd2);
    end
    chk("scan_dir_down", 32'(dir_up), 32'd0);

    // Absorb: cab button for floor 4 pressed on the second door cycle at floor 4.
    served_q.delete();
    tick(1'b1, 4'd4, '0);
    n = 0;
    while (!door_open && n < 100) begin idle_tick(); n++; end
    chk("abs_door1", 32'(door_open), 32'd1);
    chk("abs_floor", 32'(cur_floor), 32'd4);
    idle_tick();
    tick(1'b0, 4'd0, onehot(4));
    chk("abs_sv2", 32'(served_valid), 32'd1);
    chk("abs_sf2", 32'(served_floor), 32'd4);
    chk("abs_pend4", 32'(pending[4]), 32'd0);
    door_cnt = 3;
    n = 0;
    while (door_open && n < 20) begin
      idle_tick(); n++;
      if (door_open) door_cnt++;
    end
    chk("abs_door_cycles", 32'(door_cnt), 32'd5);
    chk("abs_served_pulses", 32'(served_q.size()), 32'd2);

    // Boundaries: out-of-range assignment, then stops at the top and bottom floors.
    tick(1'b1, 4'd12, '0);
    idle_tick();
    chk("bnd_drop_pending", 32'(pending), 32'd0);
    chk("bnd_drop_moving", 32'(moving), 32'd0);
    served_q.delete();
    max_floor = 0;
    tick(1'b1, 4'd10, onehot(0));
    wait_idle("bnd_done", 400);
    chk("bnd_count", 32'(served_q.size()), 32'd2);
    if (served_q.size() == 2) begin
      chk("bnd_top", 32'(served_q[0]), 32'd10);
      chk("bnd_bottom", 32'(served_q[1]), 32'd0);
    end
    chk("bnd_max_floor", 32'(max_floor), 32'd10);
    chk("bnd_final_floor", 32'(cur_floor), 32'd0);

    // Simultaneous: assignment for the current floor plus a cab request above.
    tick(1'b1, 4'd6, '0);
    wait_idle("sim_goto6", 200);
    chk("sim_at6", 32'(cur_floor), 32'd6);
    served_q.delete();
    tick(1'b1, 4'd6, onehot(8));
    chk("sim_pend6", 32'(pending[6]), 32'd1);
    seen8 = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      idle_tick(); n++;
      foreach (served_q[i]) if (served_q[i] == 8) seen8 = 1'b1;
      if (!seen8) chk("sim_pend8_held", 32'(pending[8]), 32'd1);
    end
    chk("sim_done", 32'(busy), 32'd0);
    chk("sim_count", 32'(served_q.size()), 32'd2);
    if (served_q.size() == 2) begin
      chk("sim_first", 32'(served_q[0]), 32'd6);
      chk("sim_second", 32'(served_q[1]), 32'd8);
    end

    // Asynchronous reset while moving down through floor 4.
    tick(1'b1, 4'd0, '0);
    n = 0;
    while (!(cur_floor == 4'd4 && moving) && n < 200) begin idle_tick(); n++; end
    chk("rst_mid_move", 32'(moving), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_values("rst1");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (10) idle_tick();
    chk("rst1_stay_idle", 32'(busy), 32'd0);

    // Random traffic, including out-of-range assignments and door absorbs.
    for (int i = 0; i < 3000; i++) begin
      bit av;
      logic [3:0] af;
      logic [NF-1:0] cab;
      av  = ($urandom_range(0, 5) == 0);
      af  = 4'($urandom_range(0, 15));
      cab = ($urandom_range(0, 9) == 0) ? onehot($urandom_range(0, NF - 1)) : '0;
      tick(av, af, cab);
    end
    wait_idle("rand_drain", 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lift_car_controller.md
Name: lift_car_controller

Overview:
- Per-car controller at the far end of the central dispatcher interface; one instance per lift car.
- Accepts floor assignments from the dispatcher and cab-button requests, and latches them into a pending-stop register.
- Runs a SCAN (collective) travel policy to serve the pending stops.
- Reports car floor and status back to the dispatcher: cur_floor feeds the dispatcher's liftstate input, and served_* tells the dispatcher which assignments have completed.

Parameters:
- NUM_FLOORS, 11: floors 0..NUM_FLOORS-1; must be ≤ 16.
- FLOOR_TICKS, 4: clock cycles spent in MOVE per floor travelled; must be ≥ 1.
- DOOR_TICKS, 3: clock cycles door_open is held per stop; must be ≥ 1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- assign_valid  in  1  dispatcher assignment strobe, one request per cycle
- assign_floor  in  4  floor being assigned, qualified by assign_valid
- cab_req  in  NUM_FLOORS  cab-button bitmask, level or pulse; each set bit latches that floor
- cur_floor  out  4  current car floor (dispatcher liftstate)
- dir_up  out  1  travel/preferred direction: 1 = up, 0 = down
- moving  out  1  high in MOVE state
- door_open  out  1  high in DOOR state
- served_valid  out  1  one-cycle pulse when a stop is served
- served_floor  out  4  floor served, valid with served_valid
- pending  out  NUM_FLOORS  latched, not-yet-served stops
- busy  out  1  high when state != IDLE or pending != 0

Behaviour:
- Reset values: cur_floor=0, dir_up=1, moving=0, door_open=0, served_valid=0, served_floor=0, pending=0, all timers=0, state=IDLE. Asynchronous reset is honoured at any point, including mid-MOVE or mid-DOOR; the in-flight floor step is discarded.
- Request latching, every cycle, registered:
  - pending |= cab_req.
  - pending[assign_floor] is set if assign_valid is high.
  - An assign_floor ≥ NUM_FLOORS is silently dropped.
- Absorb rule: while state=DOOR, a request for cur_floor is not latched. It restarts the door timer to DOOR_TICKS and re-pulses served_valid/served_floor=cur_floor on the next cycle.
- A set and a clear of the same bit in the same edge: set wins. The only exception is the DOOR absorb case above.
- ahead = any pending above cur_floor when dir_up=1, any pending below cur_floor when dir_up=0. behind = the opposite side.
- States: IDLE, MOVE, ARRIVE, DOOR.
  - IDLE:
    - pending[cur_floor]=1 → DOOR.
    - else ahead → MOVE.
    - else behind → toggle dir_up and go to MOVE.
    - else stay in IDLE.
  - MOVE: timer counts FLOOR_TICKS cycles. On the edge ending the last cycle, cur_floor steps ±1 per dir_up and the FSM enters ARRIVE.
  - ARRIVE (exactly one cycle):
    - pending[cur_floor] → DOOR.
    - else ahead → MOVE.
    - else → IDLE.
  - DOOR:
    - Entry edge: clear pending[cur_floor]; served_valid=1 and served_floor=cur_floor during the first DOOR cycle.
    - door_open is held DOOR_TICKS cycles (timer restarts on absorb), then → IDLE.
- Direction rules:
  - dir_up changes only in IDLE.
  - At floor 0, below is empty by definition; at NUM_FLOORS-1, above is empty. cur_floor never leaves 0..NUM_FLOORS-1.
  - With requests both above and below in IDLE, the current dir_up is kept.
- Latency: travelling n floors costs n*(FLOOR_TICKS+1) cycles from MOVE entry to the ARRIVE cycle at the target, plus 1 cycle to DOOR.
- Outputs are registered and decoded from state: moving = (state==MOVE), door_open = (state==DOOR).

Test Plan:
- Reset: assert rst mid-MOVE at floor 4 → all outputs return to reset values immediately (async). After release, the controller stays IDLE with pending=0.
- Single assignment: floor 0, assign floor 3 at cycle 0.
  - MOVE entered at cycle 2.
  - cur_floor reaches 1, 2, 3 at cycles 6, 11, 16.
  - door_open=1 with served_valid pulse (served_floor=3) at cycle 17.
  - door_open held 3 cycles, then IDLE; pending=0, busy=0.
- SCAN ordering: car moving up past floor 5 with pending {7, 2} → stop served at 7 first, then IDLE reverses dir_up=0 and serves 2. The served_floor sequence is 7, 2.
- Absorb: in DOOR at floor 4, cab_req[4] pulses on the 2nd door cycle → the door timer restarts (door_open is held 3 more cycles), a second served pulse appears for floor 4, and pending[4] stays 0.
- Boundaries:
  - assign_floor=12 → ignored; pending is unchanged.
  - Requests at floors 10 and 0 → car stops at exactly 10 and 0, and cur_floor never exceeds 10.
- Simultaneous: assign floor 6 plus cab_req bit 8 in the same cycle at floor 6 while IDLE.
  - DOOR at floor 6 first, served_floor=6.
  - Then MOVE up to 8.
  - pending[8] is retained throughout until served.
